bcd_scan_display: RTL and testbench
===================================

// Module: bcd_scan_display
// PURPOSE
//   Parametrised successor to the two-counter/two-digit display top: one block holding
//   DIGITS cascaded BCD up/down counters plus a time-multiplexed 7-segment scanner.
//   Sits between the board clock and the 8-anode display.
//   Internal prescalers replace the external 1 Hz / 381 Hz dividers.
//   Adds load, count direction, rollover flag and leading-zero blanking.
// PARAMETERS
//   DIGITS    4            number of BCD digits counted and displayed, 1..8
//   TICK_DIV  100_000_000  Clk cycles per count tick (1 Hz at 100 MHz), >=2
//   SCAN_DIV  262_144      Clk cycles per digit scan slot (~381 Hz at 100 MHz), >=2
//   BLANK_LZ  1            1 = blank leading zeros; 0 = always show every digit
// PORTS
//   Clk       in   1          system clock, all logic rising-edge
//   Reset     in   1          synchronous, active-low reset
//   En        in   1          1 = count on each tick; 0 = hold (scan continues)
//   Up        in   1          1 = count up, 0 = count down; sampled on the tick cycle
//   Load      in   1          1 = load Load_val next cycle, priority over tick
//   Load_val  in   4*DIGITS   BCD value to load, digit 0 in [3:0]
//   Count     out  4*DIGITS   current BCD count, digit 0 = least significant
//   Rollover  out  1          one-cycle pulse on wrap (up 9..9->0..0, down 0..0->9..9)
//   Anode     out  8          active-low digit enables; bit i = digit i
//   Display   out  8          active-low segments {dp,g,f,e,d,c,b,a}; dp always 1
// BEHAVIOUR
//   Reset (Reset==0 at a Clk edge):
//     Count=0, Rollover=0, Anode=8'hFF, Display=8'hFF.
//     Both prescalers and the scan index are cleared to 0.
//     Reset asserted mid-count or mid-scan discards all state.
//   Tick prescaler:
//     Counts 0..TICK_DIV-1 and wraps; tick is high for the one cycle it equals TICK_DIV-1.
//     Free-runs regardless of En.
//     Load does not reset it.
//   Count update (registered; visible the cycle after the event):
//     Load=1: Count <= Load_val, with any nibble >9 saturated to 9; Rollover=0.
//       A tick in the same cycle is ignored.
//     Else tick & En & Up: digit 0 +1; a digit at 9 becomes 0 and carries into the next.
//       All digits at 9 -> all 0, Rollover=1 for one cycle.
//     Else tick & En & !Up: digit 0 -1; a digit at 0 becomes 9 and borrows from the next.
//       All digits at 0 -> all 9, Rollover=1 for one cycle.
//     Otherwise hold; Rollover=0.
//   Scan:
//     Scan prescaler counts 0..SCAN_DIV-1; on reaching SCAN_DIV-1 the index advances.
//     Index sequence: 0,1,..,DIGITS-1,0.
//     Anode/Display are registered from the index and Count: 1 cycle latency after an
//       index change.
//     Anode[idx]=0, all other bits 1; bits >= DIGITS are always 1.
//   Decode (gfedcba, active-low):
//     0=1000000  1=1111001  2=0100100  3=0110000  4=0011001
//     5=0010010  6=0000010  7=1111000  8=0000000  9=0010000
//   Blanking (BLANK_LZ=1):
//     Digit i>0 is blanked (segments 7'h7F, anode still driven) when it and every higher
//       digit are 0.
//     Digit 0 is never blanked.
//   Width rules:
//     Prescaler widths are $clog2 of the divisor.
//     Index width is max(1,$clog2(DIGITS)); DIGITS=1 keeps Anode=8'hFE after the first slot.
// TESTING
//   (bench parameters: DIGITS=3, TICK_DIV=4, SCAN_DIV=2, BLANK_LZ=1)
//   Reset low 2 cycles, then high -> Count=12'h000, Anode=FF, Display=FF.
//     First scan slot then gives Anode=FE, Display=C0.
//   En=1, Up=1 for 40 ticks from 0 -> Count=12'h040.
//     Digit 1 reads 0x40 as 0100 (4); digit 2 blanked (Display=FF while Anode=FB).
//   Load 12'h998, En=1, Up=1 -> 999, then 000 with Rollover high exactly 1 cycle on the
//     wrap tick.
//   Load 12'h000, Up=0, one tick -> Count=12'h999, Rollover pulse.
//     Then Load 12'h1AF -> Count=12'h199.
//   Load=1 in the same cycle as a tick -> Count=Load_val, no increment.
//   Reset low mid-scan at index 2 with Count=12'h123 -> next cycle all outputs at reset
//     values; scan restarts at index 0.

Source files
------------

// File: rtl/bcd_scan_display_if.sv
// bcd_scan_display_if
//   Bundles the control inputs and display/count outputs of bcd_scan_display.
//   master : drives En/Up/Load/Load_val, observes Count/Rollover/Anode/Display
//   slave  : the display block itself
//   DIGITS sets the Load_val/Count width (4 bits per BCD digit).
interface bcd_scan_display_if #(
  parameter int DIGITS = 4
);
  logic                  En;
  logic                  Up;
  logic                  Load;
  logic [4*DIGITS-1:0]   Load_val;
  logic [4*DIGITS-1:0]   Count;
  logic                  Rollover;
  logic [7:0]            Anode;
  logic [7:0]            Display;

  modport master (
    output En, Up, Load, Load_val,
    input  Count, Rollover, Anode, Display
  );

  modport slave (
    input  En, Up, Load, Load_val,
    output Count, Rollover, Anode, Display
  );
endinterface

// File: rtl/bcd_scan_display.sv
// bcd_scan_display
//   DIGITS cascaded BCD up/down counters with an internal count-tick prescaler,
//   plus a time-multiplexed active-low 7-segment scanner with optional
//   leading-zero blanking.
// Ports
//   Clk   : system clock, rising edge
//   Reset : synchronous, active-low
//   bus   : bcd_scan_display_if.slave
//           En/Up/Load/Load_val in; Count/Rollover/Anode/Display out
//           Display = {dp,g,f,e,d,c,b,a}, dp held at 1
module bcd_scan_display #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 100_000_000,
  parameter int SCAN_DIV = 262_144,
  parameter int BLANK_LZ = 1
) (
  input  logic                Clk,
  input  logic                Reset,
  bcd_scan_display_if.slave   bus
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  logic [TW-1:0]              tick_q;
  logic [SW-1:0]              scan_q;
  logic [IW-1:0]              idx_q;
  logic [DIGITS-1:0][3:0]     cnt_q;
  logic [DIGITS-1:0][3:0]     cnt_step_d;
  logic [DIGITS-1:0][3:0]     cnt_ld_d;
  logic [DIGITS-1:0][6:0]     seg_d;
  logic [DIGITS-1:0]          blank_d;
  logic                       roll_q;
  logic                       wrap_d;
  logic [7:0]                 anode_q, anode_d;
  logic [7:0]                 disp_q;
  logic                       tick, scan_tick;

  assign tick      = (tick_q == TW'(TICK_DIV - 1));
  assign scan_tick = (scan_q == SW'(SCAN_DIV - 1));

  // Ripple carry/borrow through the digits; wrap_d stays set only when every
  // digit wrapped, which is exactly the rollover condition.
  always_comb begin
    logic cy;
    cnt_step_d = cnt_q;
    cy         = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (cy) begin
        if (bus.Up) begin
          if (cnt_q[i] == 4'd9) cnt_step_d[i] = 4'd0;
          else begin
            cnt_step_d[i] = cnt_q[i] + 4'd1;
            cy            = 1'b0;
          end
        end else begin
          if (cnt_q[i] == 4'd0) cnt_step_d[i] = 4'd9;
          else begin
            cnt_step_d[i] = cnt_q[i] - 4'd1;
            cy            = 1'b0;
          end
        end
      end
    end
    wrap_d = cy;
  end

  // A digit is a leading zero when it and everything above it is zero.
  // Digit 0 always shows so a zero count still reads "0".
  always_comb begin
    logic zhi;
    zhi     = 1'b1;
    blank_d = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zhi = zhi && (cnt_q[i] == 4'd0);
      if (i > 0 && BLANK_LZ != 0) blank_d[i] = zhi;
    end
  end

  // Per-digit load saturation and segment decode.
  for (genvar g = 0; g < DIGITS; g++) begin : g_lane
    logic [3:0] lv;
    assign lv          = bus.Load_val[4*g +: 4];
    assign cnt_ld_d[g] = (lv > 4'd9) ? 4'd9 : lv;
    assign seg_d[g]    = blank_d[g] ? 7'h7F : seg7(cnt_q[g]);
  end

  always_comb begin
    anode_d        = 8'hFF;
    anode_d[idx_q] = 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      tick_q  <= '0;
      scan_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      roll_q  <= 1'b0;
      anode_q <= 8'hFF;
      disp_q  <= 8'hFF;
    end else begin
      // Tick prescaler free-runs; neither En nor Load disturbs its phase.
      tick_q <= tick ? '0 : tick_q + TW'(1);
      scan_q <= scan_tick ? '0 : scan_q + SW'(1);
      if (scan_tick)
        idx_q <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);

      roll_q <= 1'b0;
      if (bus.Load) begin
        cnt_q <= cnt_ld_d;
      end else if (tick && bus.En) begin
        cnt_q  <= cnt_step_d;
        roll_q <= wrap_d;
      end

      anode_q <= anode_d;
      disp_q  <= {1'b1, seg_d[idx_q]};
    end
  end

  assign bus.Count    = cnt_q;
  assign bus.Rollover = roll_q;
  assign bus.Anode    = anode_q;
  assign bus.Display  = disp_q;
endmodule

// File: tb/tb_bcd_scan_display.sv
module tb_bcd_scan_display;
  localparam int DIGITS = 3;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  bcd_scan_display_if #(.DIGITS(DIGITS)) bus();

  bcd_scan_display #(
    .DIGITS(DIGITS), .TICK_DIV(4), .SCAN_DIV(2), .BLANK_LZ(1)
  ) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [11:0] lv;
    logic [11:0] exp_cnt;
    logic [7:0]  exp_d0;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic load(input logic [11:0] v);
    bus.Load     = 1'b1;
    bus.Load_val = v;
    step();
    bus.Load     = 1'b0;
  endtask

  // Bounded wait until the given anode pattern is on the outputs.
  task automatic wait_anode(input logic [7:0] a, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.Anode == a) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  initial begin
    bit ok;
    int hi_before;
    bit seen999, done;
    logic [11:0] prev;

    vecs[0]  = '{12'h998, 12'h998, 8'h80};
    vecs[1]  = '{12'h1AF, 12'h199, 8'h90};
    vecs[2]  = '{12'hFFF, 12'h999, 8'h90};
    vecs[3]  = '{12'h123, 12'h123, 8'hB0};
    vecs[4]  = '{12'hA05, 12'h905, 8'h92};
    vecs[5]  = '{12'h000, 12'h000, 8'hC0};
    vecs[6]  = '{12'h001, 12'h001, 8'hF9};
    vecs[7]  = '{12'h002, 12'h002, 8'hA4};
    vecs[8]  = '{12'h004, 12'h004, 8'h99};
    vecs[9]  = '{12'h006, 12'h006, 8'h82};
    vecs[10] = '{12'h007, 12'h007, 8'hF8};

    bus.En = 1'b0; bus.Up = 1'b0; bus.Load = 1'b0; bus.Load_val = '0;

    // Reset
    Reset = 1'b0;
    step(); step();
    chk("rst_count", bus.Count, 12'h000);
    chk("rst_anode", bus.Anode, 8'hFF);
    chk("rst_disp",  bus.Display, 8'hFF);
    chk("rst_roll",  bus.Rollover, 1'b0);

    Reset = 1'b1; bus.En = 1'b1; bus.Up = 1'b1;
    step();
    chk("slot0_anode", bus.Anode, 8'hFE);
    chk("slot0_disp",  bus.Display, 8'hC0);

    // 40 ticks: prescaler fires on every 4th edge after release
    repeat (159) step();
    chk("cnt40", bus.Count, 12'h040);
    bus.En = 1'b0;
    step();
    wait_anode(8'hFD, ok);
    chk("seen_d1", ok, 1'b1);
    chk("d1_four", bus.Display, 8'h99);
    wait_anode(8'hFB, ok);
    chk("seen_d2", ok, 1'b1);
    chk("d2_blank", bus.Display, 8'hFF);
    wait_anode(8'hFE, ok);
    chk("seen_d0", ok, 1'b1);
    chk("d0_zero", bus.Display, 8'hC0);

    // Load / saturation / decode table
    foreach (vecs[k]) begin
      load(vecs[k].lv);
      chk($sformatf("ld_cnt[%0d]", k), bus.Count, vecs[k].exp_cnt);
      step();
      wait_anode(8'hFE, ok);
      chk($sformatf("ld_seen[%0d]", k), ok, 1'b1);
      chk($sformatf("ld_seg[%0d]", k), bus.Display, vecs[k].exp_d0);
      chk($sformatf("ld_hi[%0d]", k), bus.Anode[7:3], 5'b11111);
    end

    // Up wrap 998 -> 999 -> 000
    bus.Up = 1'b1;
    load(12'h998);
    bus.En = 1'b1;
    hi_before = 0; seen999 = 1'b0; done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.Count == 12'h999) seen999 = 1'b1;
      if (bus.Count == 12'h000) begin
        done = 1'b1;
        break;
      end
      if (bus.Rollover) hi_before++;
    end
    bus.En = 1'b0;
    chk("up_seen999", seen999, 1'b1);
    chk("up_wrapped", done, 1'b1);
    chk("up_roll", bus.Rollover, 1'b1);
    chk("up_roll_early", hi_before, 0);
    step();
    chk("up_roll_1cyc", bus.Rollover, 1'b0);
    chk("up_cnt0", bus.Count, 12'h000);

    // Down wrap 000 -> 999
    bus.Up = 1'b0;
    load(12'h000);
    bus.En = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.Count != 12'h000) break;
    end
    bus.En = 1'b0;
    chk("dn_cnt", bus.Count, 12'h999);
    chk("dn_roll", bus.Rollover, 1'b1);
    step();
    chk("dn_roll_1cyc", bus.Rollover, 1'b0);
    load(12'h1AF);
    chk("dn_ld_sat", bus.Count, 12'h199);

    // Load coinciding with a tick: find the tick phase from a count change
    bus.Up = 1'b1; bus.En = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      prev = bus.Count;
      step();
      if (bus.Count != prev) begin
        done = 1'b1;
        break;
      end
    end
    chk("tick_found", done, 1'b1);
    repeat (3) step();
    load(12'h500);
    bus.En = 1'b0;
    chk("ld_tick", bus.Count, 12'h500);
    step();
    chk("ld_tick_hold", bus.Count, 12'h500);

    // Reset in the middle of a scan, at digit 2
    load(12'h123);
    step();
    wait_anode(8'hFB, ok);
    chk("mid_seen_d2", ok, 1'b1);
    chk("mid_d2", bus.Display, 8'hF9);
    Reset = 1'b0;
    step();
    chk("mid_rst_cnt", bus.Count, 12'h000);
    chk("mid_rst_anode", bus.Anode, 8'hFF);
    chk("mid_rst_disp", bus.Display, 8'hFF);
    chk("mid_rst_roll", bus.Rollover, 1'b0);
    Reset = 1'b1;
    step();
    chk("restart_anode", bus.Anode, 8'hFE);
    chk("restart_disp", bus.Display, 8'hC0);
    step(); step();
    chk("restart_anode1", bus.Anode, 8'hFD);
    chk("restart_blank1", bus.Display, 8'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
